// File: rtl/mem_access_pkg.sv
// Shared definitions for the memory-access stage: widths, opcodes and
// opcode-classification helpers.
package mem_access_pkg;

    localparam int ADDR_LEN = 32;
    localparam int REG_LEN  = 32;
    localparam int OP_LEN   = 5;

    localparam logic [REG_LEN-1:0] ZERO_WORD     = '0;
    localparam logic [4:0]         REG_ADDR_ZERO = 5'd0;

    localparam logic [OP_LEN-1:0] OP_NOP   = 5'd0;
    localparam logic [OP_LEN-1:0] OP_ADD   = 5'd1;
    localparam logic [OP_LEN-1:0] OP_ADDI  = 5'd2;
    localparam logic [OP_LEN-1:0] OP_SUB   = 5'd3;
    localparam logic [OP_LEN-1:0] OP_AND   = 5'd4;
    localparam logic [OP_LEN-1:0] OP_OR    = 5'd5;
    localparam logic [OP_LEN-1:0] OP_LUI   = 5'd6;
    localparam logic [OP_LEN-1:0] OP_AUIPC = 5'd7;
    localparam logic [OP_LEN-1:0] OP_LB    = 5'd16;
    localparam logic [OP_LEN-1:0] OP_LH    = 5'd17;
    localparam logic [OP_LEN-1:0] OP_LW    = 5'd18;
    localparam logic [OP_LEN-1:0] OP_LBU   = 5'd19;
    localparam logic [OP_LEN-1:0] OP_LHU   = 5'd20;
    localparam logic [OP_LEN-1:0] OP_SB    = 5'd21;
    localparam logic [OP_LEN-1:0] OP_SH    = 5'd22;
    localparam logic [OP_LEN-1:0] OP_SW    = 5'd23;

    function automatic logic is_load(input logic [OP_LEN-1:0] op);
        return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
    endfunction

    function automatic logic is_store(input logic [OP_LEN-1:0] op);
        return op inside {OP_SB, OP_SH, OP_SW};
    endfunction

    // Number of bytes moved on the byte-serial port for a memory op.
    function automatic logic [2:0] byte_count(input logic [OP_LEN-1:0] op);
        logic [2:0] n;
        case (op)
            OP_LB, OP_LBU, OP_SB: n = 3'd1;
            OP_LH, OP_LHU, OP_SH: n = 3'd2;
            default:              n = 3'd4;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/mem_access_load_ext.sv
// Sign/zero extension of the assembled load bytes according to the load op.
module mem_access_load_ext
    import mem_access_pkg::*;
(
    input  logic [OP_LEN-1:0]  op,
    input  logic [REG_LEN-1:0] raw,
    output logic [REG_LEN-1:0] data
);

    always_comb begin
        data = raw;
        case (op)
            OP_LB:   data = {{24{raw[7]}}, raw[7:0]};
            OP_LH:   data = {{16{raw[15]}}, raw[15:0]};
            OP_LBU:  data = {24'h000000, raw[7:0]};
            OP_LHU:  data = {16'h0000, raw[15:0]};
            default: data = raw;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// RV32I memory-access stage: byte-serial loads/stores on the memory-controller
// port, single-cycle pass-through otherwise. MEM_ALIGN_CHECK_EN enables misalignment faults.
module mem_access
    import mem_access_pkg::*;
#(
    parameter int ADDR_W = ADDR_LEN,
    parameter int DATA_W = REG_LEN
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              in_valid,
    input  logic [OP_LEN-1:0] op_i,
    input  logic [DATA_W-1:0] rd_data_i,
    input  logic [4:0]        rd_addr_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic [4:0]        rd_addr_o,
    output logic              wb_valid,
    output logic              mem_stall,
    output logic              mc_req,
    output logic              mc_wr,
    output logic [ADDR_W-1:0] mc_addr,
    output logic [7:0]        mc_wdata,
    input  logic [7:0]        mc_rdata,
    input  logic              mc_ack,
    output logic              misalign
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t            state;
    logic [2:0]        cnt;
    logic [2:0]        cnt_max;
    logic [OP_LEN-1:0] op_q;
    logic [ADDR_W-1:0] base_q;
    logic [DATA_W-1:0] st_data_q;
    logic [DATA_W-1:0] ld_buf_q;
    logic [4:0]        rd_q;

    logic              mem_op;
    logic              misaligned;
    logic              accept_mem;
    logic              ack;
    logic              last_byte;
    logic [4:0]        lane_lsb;
    logic [DATA_W-1:0] ld_assembled;
    logic [DATA_W-1:0] ld_result;

    assign mem_op = is_load(op_i) || is_store(op_i);

`ifdef MEM_ALIGN_CHECK_EN
    assign misaligned = ((op_i == OP_LH || op_i == OP_LHU || op_i == OP_SH) && mem_addr_i[0])
                     || ((op_i == OP_LW || op_i == OP_SW) && (mem_addr_i[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    assign accept_mem = (state == IDLE) && in_valid && mem_op && !misaligned;
    assign ack        = rdy && mc_ack && (state == BUSY);
    assign last_byte  = (cnt == cnt_max - 3'd1);
    assign lane_lsb   = {cnt[1:0], 3'b000};

    // Stall releases in the final-ack cycle so ex_mem advances on that edge.
    assign mem_stall = !rst && (accept_mem || ((state == BUSY) && !(ack && last_byte)));
    assign mc_req    = !rst && rdy && (state == BUSY);
    assign mc_wr     = (state == BUSY) && is_store(op_q);
    assign mc_addr   = (state == BUSY) ? base_q + ADDR_W'(cnt) : '0;
    assign mc_wdata  = (state == BUSY) ? st_data_q[lane_lsb +: 8] : 8'h00;

    always_comb begin
        ld_assembled = ld_buf_q;
        ld_assembled[lane_lsb +: 8] = mc_rdata;
    end

    mem_access_load_ext u_load_ext (
        .op   (op_q),
        .raw  (ld_assembled),
        .data (ld_result)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 3'd0;
            cnt_max   <= 3'd0;
            op_q      <= OP_NOP;
            base_q    <= '0;
            st_data_q <= '0;
            ld_buf_q  <= '0;
            rd_q      <= REG_ADDR_ZERO;
            rd_data_o <= '0;
            rd_addr_o <= REG_ADDR_ZERO;
            wb_valid  <= 1'b0;
        end else if (rdy) begin
            case (state)
                IDLE: begin
                    cnt <= 3'd0;
                    if (in_valid && mem_op && misaligned) begin
                        rd_data_o <= '0;
                        rd_addr_o <= REG_ADDR_ZERO;
                        wb_valid  <= 1'b1;
                    end else if (accept_mem) begin
                        op_q      <= op_i;
                        base_q    <= mem_addr_i;
                        st_data_q <= rd_data_i;
                        rd_q      <= rd_addr_i;
                        cnt_max   <= byte_count(op_i);
                        ld_buf_q  <= '0;
                        rd_addr_o <= REG_ADDR_ZERO;
                        wb_valid  <= 1'b0;
                        state     <= BUSY;
                    end else if (in_valid && op_i != OP_NOP) begin
                        rd_data_o <= rd_data_i;
                        rd_addr_o <= rd_addr_i;
                        wb_valid  <= 1'b1;
                    end else begin
                        rd_addr_o <= REG_ADDR_ZERO;
                        wb_valid  <= 1'b0;
                    end
                end
                BUSY: begin
                    wb_valid <= 1'b0;
                    if (ack) begin
                        if (is_load(op_q)) begin
                            ld_buf_q <= ld_assembled;
                        end
                        if (last_byte) begin
                            state    <= IDLE;
                            cnt      <= 3'd0;
                            wb_valid <= 1'b1;
                            if (is_load(op_q)) begin
                                rd_data_o <= ld_result;
                                rd_addr_o <= rd_q;
                            end else begin
                                rd_data_o <= '0;
                                rd_addr_o <= REG_ADDR_ZERO;
                            end
                        end else begin
                            cnt <= cnt + 3'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MEM_ALIGN_CHECK_EN
    // The fault pulse lines up with the wb_valid of the rejected access.
    always_ff @(posedge clk) begin
        if (rst) begin
            misalign <= 1'b0;
        end else if (rdy) begin
            misalign <= (state == IDLE) && in_valid && mem_op && misaligned;
        end
    end
`else
    assign misalign = 1'b0;
`endif

endmodule
